// File: rtl/wb_regfile_if.sv
// cpu_pkg: shared CPU types (opcodes, instruction word, EX/WB bundle).
// wb_regfile_if: bus between the pipeline and the writeback/register-file block.
//   slave  (register file): takes ex_wb_pipe and rs*_addr; drives rs*_data, wb_*, retired, halted
//   master (pipeline/bench): the mirror image of slave
package cpu_pkg;

    typedef logic signed [31:0] sint32_t;

    typedef enum logic [5:0] {
        NA   = 6'd0,
        ADD  = 6'd1,
        SUB  = 6'd2,
        AND  = 6'd3,
        OR   = 6'd4,
        XOR  = 6'd5,
        SLT  = 6'd6,
        ADDI = 6'd7,
        LUI  = 6'd8,
        LW   = 6'd9,
        SW   = 6'd10,
        SB   = 6'd11,
        BEQ  = 6'd12,
        BNE  = 6'd13,
        BLT  = 6'd14,
        JAL  = 6'd15,
        HALT = 6'd63
    } opcode_t;

    typedef struct packed {
        opcode_t     opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [15:0] imm;
    } IR_t;

    typedef struct packed {
        IR_t     IR;
        sint32_t C;
    } EX_WB_pipe_t;

endpackage

interface wb_regfile_if;
    import cpu_pkg::*;

    EX_WB_pipe_t ex_wb_pipe;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    sint32_t     rs1_data;
    sint32_t     rs2_data;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] retired;
    logic        halted;

    modport slave (
        input  ex_wb_pipe, rs1_addr, rs2_addr,
        output rs1_data, rs2_data, wb_valid, wb_addr, wb_data, retired, halted
    );

    modport master (
        output ex_wb_pipe, rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, wb_valid, wb_addr, wb_data, retired, halted
    );

endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage + architectural register file.
// Commits ex_wb_pipe.C to IR.rd on the posedge, serves two combinational
// read ports with write-through bypass, counts retirements and holds a
// sticky halt state that only reset clears.
//   clk    : clock, all state on posedge
//   resetn : asynchronous active-low reset
//   bus    : wb_regfile_if.slave (EX/WB bundle in, read ports, wb_* observability,
//            retired counter, halted flag)

// One combinational read port. r0 forcing wins over bypass, bypass wins over
// the stored value so decode sees this cycle's commit without a stall.
module wb_regfile_rdport #(
    parameter int NREGS   = 32,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic [4:0]             addr,
    input  logic [NREGS-1:0][31:0] regs,
    input  logic                   we,
    input  logic [4:0]             wr_addr,
    input  logic [31:0]            wr_data,
    output logic [31:0]            data
);
    always_comb begin
        data = '0;
        if (R0_ZERO && addr == 5'd0)
            data = '0;
        else if (we && addr == wr_addr)
            data = wr_data;
        else if (32'(addr) < 32'(NREGS))
            data = regs[addr];
    end
endmodule

module wb_regfile
    import cpu_pkg::*;
#(
    parameter int NREGS   = 32,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic       clk,
    input  logic       resetn,
    wb_regfile_if.slave bus
);
    localparam int NUM_PORTS = 2;

    typedef enum logic {RUN, HALTED} state_t;

    state_t                 state_q, state_d;
    logic [NREGS-1:0][31:0] regs;
    logic [31:0]            retire_cnt;
    logic                   wb_valid_q;
    logic [4:0]             wb_addr_q;
    logic [31:0]            wb_data_q;

    opcode_t     opcode;
    logic [4:0]  rd;
    logic [31:0] c_val;
    logic        writing;
    logic        retire;
    logic        we;
    logic        rd_in_range;

    assign opcode      = bus.ex_wb_pipe.IR.opcode;
    assign rd          = bus.ex_wb_pipe.IR.rd;
    assign c_val       = bus.ex_wb_pipe.C;
    assign rd_in_range = 32'(rd) < 32'(NREGS);

    // Decode-only fields travel in the bundle but are not needed here.
    logic unused_ir;
    assign unused_ir = ^{bus.ex_wb_pipe.IR.rs1, bus.ex_wb_pipe.IR.rs2, bus.ex_wb_pipe.IR.imm};

    // Stores, branches and HALT retire without touching the register file.
    always_comb begin
        writing = 1'b1;
        case (opcode)
            NA, SW, SB, BEQ, BNE, BLT, HALT: writing = 1'b0;
            default:                         writing = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= RUN;
        else         state_q <= state_d;
    end

    // HALTED swallows everything on the pipe until reset.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        we      = 1'b0;
        case (state_q)
            RUN: begin
                retire = (opcode != NA);
                we     = writing && rd_in_range && !(R0_ZERO && rd == 5'd0);
                if (opcode == HALT) state_d = HALTED;
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            regs <= '0;
        end else if (we) begin
            regs[rd] <= c_val;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) retire_cnt <= '0;
        else if (retire) retire_cnt <= retire_cnt + 32'd1;
    end

    // wb_valid tracks every edge; address/data keep the last commit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= we;
            if (we) begin
                wb_addr_q <= rd;
                wb_data_q <= c_val;
            end
        end
    end

    logic [NUM_PORTS-1:0][4:0]  rd_addr;
    logic [NUM_PORTS-1:0][31:0] rd_data;

    assign rd_addr[0] = bus.rs1_addr;
    assign rd_addr[1] = bus.rs2_addr;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_rd
        wb_regfile_rdport #(
            .NREGS   (NREGS),
            .R0_ZERO (R0_ZERO)
        ) u_rd (
            .addr    (rd_addr[g]),
            .regs    (regs),
            .we      (we),
            .wr_addr (rd),
            .wr_data (c_val),
            .data    (rd_data[g])
        );
    end

    assign bus.rs1_data = rd_data[0];
    assign bus.rs2_data = rd_data[1];
    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_addr  = wb_addr_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.retired  = retire_cnt;
    assign bus.halted   = (state_q == HALTED);

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;
    import cpu_pkg::*;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    wb_regfile_if bus();

    wb_regfile #(
        .NREGS   (32),
        .R0_ZERO (1'b1)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input opcode_t op, input logic [4:0] rd, input logic [31:0] c);
        EX_WB_pipe_t p;
        p           = '0;
        p.IR.opcode = op;
        p.IR.rd     = rd;
        p.C         = c;
        bus.ex_wb_pipe = p;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        bus.rs1_addr = 5'd0;
        bus.rs2_addr = 5'd0;
        drive(NA, 5'd0, 32'h0);
        #3;
        check("rst_wb_valid", {31'b0, bus.wb_valid}, 32'h0);
        check("rst_retired",  bus.retired, 32'h0);
        check("rst_halted",   {31'b0, bus.halted}, 32'h0);
        step();
        resetn = 1'b1;

        // Write r5 with both ports reading it through the bypass.
        drive(ADD, 5'd5, 32'h1234_5678);
        bus.rs1_addr = 5'd5;
        bus.rs2_addr = 5'd5;
        #1;
        check("byp_rs1", bus.rs1_data, 32'h1234_5678);
        check("byp_rs2", bus.rs2_data, 32'h1234_5678);
        step();
        drive(NA, 5'd0, 32'h0);
        #1;
        check("reg_rs1",   bus.rs1_data, 32'h1234_5678);
        check("reg_rs2",   bus.rs2_data, 32'h1234_5678);
        check("wb_valid1", {31'b0, bus.wb_valid}, 32'h1);
        check("wb_addr1",  {27'b0, bus.wb_addr}, 32'd5);
        check("wb_data1",  bus.wb_data, 32'h1234_5678);
        check("retired1",  bus.retired, 32'd1);

        // Write to r0 is dropped but still retires.
        drive(ADD, 5'd0, 32'hDEAD_BEEF);
        bus.rs1_addr = 5'd0;
        #1;
        check("r0_byp", bus.rs1_data, 32'h0);
        step();
        check("r0_read",     bus.rs1_data, 32'h0);
        check("r0_wb_valid", {31'b0, bus.wb_valid}, 32'h0);
        check("r0_wb_addr",  {27'b0, bus.wb_addr}, 32'd5);
        check("r0_retired",  bus.retired, 32'd2);

        // Bubble: no write, no retire.
        drive(NA, 5'd6, 32'h0000_AAAA);
        bus.rs1_addr = 5'd6;
        #1;
        check("bub_byp", bus.rs1_data, 32'h0);
        step();
        check("bub_read",    bus.rs1_data, 32'h0);
        check("bub_retired", bus.retired, 32'd2);
        check("bub_wb_valid", {31'b0, bus.wb_valid}, 32'h0);

        // r7 = 0x77, then store and branch aimed at r7 must not write it.
        drive(ADDI, 5'd7, 32'h77);
        step();
        drive(SW, 5'd7, 32'hFF);
        bus.rs1_addr = 5'd7;
        #1;
        check("sw_byp", bus.rs1_data, 32'h77);
        step();
        drive(BEQ, 5'd7, 32'hFF);
        #1;
        check("beq_byp", bus.rs1_data, 32'h77);
        step();
        drive(NA, 5'd0, 32'h0);
        #1;
        check("nw_r7",      bus.rs1_data, 32'h77);
        check("nw_retired", bus.retired, 32'd5);
        check("nw_wb_data", bus.wb_data, 32'h77);

        // Independent ports: one bypass, one stored value.
        drive(SUB, 5'd8, 32'hCAFE_0008);
        bus.rs1_addr = 5'd8;
        bus.rs2_addr = 5'd5;
        #1;
        check("dual_rs1", bus.rs1_data, 32'hCAFE_0008);
        check("dual_rs2", bus.rs2_data, 32'h1234_5678);
        step();
        // Back-to-back to r8: last writer wins.
        drive(OR, 5'd8, 32'h0000_0888);
        #1;
        check("b2b_byp", bus.rs1_data, 32'h0000_0888);
        step();
        drive(NA, 5'd0, 32'h0);
        #1;
        check("b2b_reg",     bus.rs1_data, 32'h0000_0888);
        check("b2b_retired", bus.retired, 32'd7);

        // Reset mid-stream with a writing op on the pipe.
        drive(ADD, 5'd9, 32'h99);
        bus.rs1_addr = 5'd1;
        bus.rs2_addr = 5'd2;
        #1;
        resetn = 1'b0;
        #1;
        check("mrst_wb_valid", {31'b0, bus.wb_valid}, 32'h0);
        check("mrst_wb_addr",  {27'b0, bus.wb_addr}, 32'h0);
        check("mrst_wb_data",  bus.wb_data, 32'h0);
        check("mrst_retired",  bus.retired, 32'h0);
        check("mrst_halted",   {31'b0, bus.halted}, 32'h0);
        step();
        drive(NA, 5'd0, 32'h0);
        resetn = 1'b1;
        for (int i = 1; i < 32; i++) begin
            bus.rs1_addr = 5'(i);
            bus.rs2_addr = 5'(32 - i);
            #1;
            check($sformatf("clr_rs1_r%0d", i), bus.rs1_data, 32'h0);
            check($sformatf("clr_rs2_r%0d", 32 - i), bus.rs2_data, 32'h0);
        end
        check("clr_retired", bus.retired, 32'h0);

        // Halt: r3 = 4, HALT, then a write to r3 that must be dropped.
        @(negedge clk);
        drive(ADD, 5'd3, 32'h4);
        step();
        drive(HALT, 5'd3, 32'h0);
        bus.rs1_addr = 5'd3;
        #1;
        check("halt_byp", bus.rs1_data, 32'h4);
        step();
        drive(ADD, 5'd3, 32'h9);
        #1;
        check("halt_flag",     {31'b0, bus.halted}, 32'h1);
        check("halt_retired",  bus.retired, 32'd2);
        check("halt_wb_valid", {31'b0, bus.wb_valid}, 32'h0);
        check("halt_nobyp",    bus.rs1_data, 32'h4);
        step();
        check("post_r3",       bus.rs1_data, 32'h4);
        check("post_retired",  bus.retired, 32'd2);
        check("post_wb_valid", {31'b0, bus.wb_valid}, 32'h0);
        check("post_wb_addr",  {27'b0, bus.wb_addr}, 32'd3);
        check("post_wb_data",  bus.wb_data, 32'h4);
        step();
        step();
        check("halt_sticky", {31'b0, bus.halted}, 32'h1);

        // Counter wrap.
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
        check("wrap_unhalt", {31'b0, bus.halted}, 32'h0);
        drive(ADD, 5'd1, 32'h1);
        bus.rs1_addr = 5'd1;
        force dut.retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt;
        #1;
        check("wrap_pre", bus.retired, 32'hFFFF_FFFF);
        step();
        drive(NA, 5'd0, 32'h0);
        #1;
        check("wrap_post", bus.retired, 32'h0);
        check("wrap_r1",   bus.rs1_data, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and architectural register file of the 5-stage CPU. It consumes the registered `ex_wb_pipe` bundle from the EX/WB pipeline register, commits the result `C` to the destination register, and serves the two combinational read ports used by decode. A write-through bypass returns the value being committed this cycle. It also tracks retired instructions and a sticky halt state.

## Interface

- `NREGS`, 32: number of architectural registers. Indexed by the 5-bit `rd`, `rs1` and `rs2` fields.
- `R0_ZERO`, 1: when 1, r0 reads as 0 and writes to r0 are dropped.

Ports, with clock and reset first:

- `clk`  input  1: single clock. All state updates on the posedge.
- `resetn`  input  1: asynchronous, active-low reset.
- `ex_wb_pipe`  input  `EX_WB_pipe_t`: EX/WB bundle. Fields used are `IR.opcode`, `IR.rd` and `C` (`sint32_t`).
- `rs1_addr`  input  5: decode read address, port 1.
- `rs2_addr`  input  5: decode read address, port 2.
- `rs1_data`  output  32 (`sint32_t`): combinational read data, port 1.
- `rs2_data`  output  32 (`sint32_t`): combinational read data, port 2.
- `wb_valid`  output  1: registered. A commit happened on the previous edge.
- `wb_addr`  output  5: registered. Register written on the previous edge.
- `wb_data`  output  32: registered. Value written on the previous edge.
- `retired`  output  32: count of committed instructions.
- `halted`  output  1: sticky halt flag.

## Operation

**Instruction classification** (uses `cpu_pkg` opcode names)
- Bubble: `opcode == NA`. No write, not retired.
- Non-writing: store, branch and HALT. Retired, no write.
- All other opcodes write `C` to `rd`.
- Commit-write enable: `we = writing && !halted && !(R0_ZERO && rd == 0)`.

**State machine** (2 states: RUN, HALTED)
- RUN → HALTED on the edge where a HALT opcode is present. HALT itself is retired.
- HALTED is left only by reset.
- In HALTED, all writes and retirements are suppressed regardless of `ex_wb_pipe`.

**Register file**
- `NREGS` × 32-bit flops.
- Written on the posedge while `we = 1`, with `regs[rd] <= C`.

**Reads**
- Combinational.
- If `R0_ZERO` and the address is 0, the result is 0.
- Otherwise, if `we` and the address equals `rd`, the result is `C` (bypass).
- Otherwise the result is `regs[addr]`.
- Both ports are independent. Both may hit the bypass in the same cycle.

**Retire counter**
- +1 per retired instruction.
- 32-bit unsigned. Wraps 0xFFFF_FFFF → 0 with no flag.

**Observability registers**
- `wb_valid <= we`, `wb_addr <= rd`, `wb_data <= C`.
- Address and data update only when `we`. Otherwise they hold their value.

**Reset** (asynchronous assert, takes effect immediately)
- All registers = 0.
- `retired` = 0, `halted` = 0, state = RUN.
- `wb_valid` = 0, `wb_addr` = 0, `wb_data` = 0.
- Reset asserted mid-stream discards any in-flight commit. No partial write.

## Timing

- An instruction present on `ex_wb_pipe` in cycle N is committed at the end of cycle N, on the posedge.
- Its value is visible on the read ports during cycle N via the bypass, and from `regs` in cycle N+1.
- Decode reading in the same cycle as the writeback therefore sees the new value. No WB→ID stall is needed.
- `wb_*`, `retired` and `halted` reflect cycle N's commit from cycle N+1 onward.
- `rs*_data` are combinational in `rs*_addr` and `ex_wb_pipe`, with no registered latency.
- Back-to-back writes to the same `rd`: the last one wins. Each is bypassed in its own cycle.
- HALT and a write to the same edge cannot coincide, because HALT is non-writing.
- An instruction following HALT is never committed.

## Test plan

- **Reset:** assert `resetn = 0` mid-run with a writing op on the pipe → all outputs 0. After release, reading r1..r31 returns 0 and `retired` = 0.
- **Write/read/bypass:** ALU op with `rd` = 5, `C` = 0x1234_5678, and `rs1_addr` = `rs2_addr` = 5 in the same cycle → both reads give 0x1234_5678 that cycle and the next. `wb_valid` = 1, `wb_addr` = 5 the next cycle.
- **r0 and bubbles:** write `rd` = 0, `C` = 0xDEAD_BEEF → read r0 returns 0 and `wb_valid` = 0, `retired` +1. An NA bubble → `retired` unchanged and no write.
- **Non-writing ops:** store and branch with `rd` = 7, `C` = 0xFF → r7 unchanged and `retired` +2.
- **Halt:** HALT, then ALU `rd` = 3, `C` = 9 → `halted` = 1 on the next cycle, r3 unchanged, `retired` counts HALT only. `halted` stays 1 until reset.
- **Counter wrap:** force `retired` to 0xFFFF_FFFF, then retire one op → `retired` = 0.
